// File: rtl/pump_drive_sequencer.sv
// rtl/pump_drive_sequencer.sv - single-owner pump duty sequencer with slew limit, dead time and estop
module pump_drive_sequencer #(
  parameter int RAMP_STEP_CYCLES = 500_000,
  parameter int DUTY_STEP        = 5,
  parameter int DEAD_TIME_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] req_duty_a,
  input  logic [7:0] req_duty_b,
  input  logic       estop,
  output logic [7:0] pwm_duty_a,
  output logic [7:0] pwm_duty_b,
  output logic       busy,
  output logic       settled,
  output logic       conflict
);

  localparam int PW = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
  localparam int DW = (DEAD_TIME_CYCLES > 1) ? $clog2(DEAD_TIME_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_STEP_CYCLES - 1);
  localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_TIME_CYCLES - 1);
  localparam logic [8:0]    STEP9      = 9'(DUTY_STEP);

  typedef enum logic [1:0] {IDLE, RUN_A, RUN_B, DEAD_TIME} state_t;

  state_t          r_state;
  logic [7:0]      r_duty_a;
  logic [7:0]      r_duty_b;
  logic [PW-1:0]   r_presc;
  logic [DW-1:0]   r_dead_cnt;
  logic            r_settled;

  logic [7:0]      w_tgt_a;
  logic [7:0]      w_tgt_b;
  logic [7:0]      w_next_a;
  logic [7:0]      w_next_b;
  logic            w_step;

  // 9-bit arithmetic so the step can neither wrap past 0/255 nor overshoot the target
  function automatic logic [7:0] f_toward(input logic [7:0] duty, input logic [7:0] tgt);
    logic [8:0] w_d;
    logic [8:0] w_t;
    logic [8:0] w_up;
    logic [8:0] w_dn;
    w_d  = {1'b0, duty};
    w_t  = {1'b0, tgt};
    w_up = w_d + STEP9;
    w_dn = w_d - STEP9;
    if (w_t > w_d)
      return ((w_t - w_d) <= STEP9) ? tgt : w_up[7:0];
    else if (w_d > w_t)
      return ((w_d - w_t) <= STEP9) ? tgt : w_dn[7:0];
    else
      return duty;
  endfunction

  assign w_tgt_a  = (req_duty_b == 8'd0) ? req_duty_a : 8'd0;
  assign w_tgt_b  = (req_duty_a == 8'd0) ? req_duty_b : 8'd0;
  assign w_step   = (r_presc == PRESC_LAST);
  assign w_next_a = w_step ? f_toward(r_duty_a, w_tgt_a) : r_duty_a;
  assign w_next_b = w_step ? f_toward(r_duty_b, w_tgt_b) : r_duty_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= DEAD_TIME;
      r_duty_a   <= 8'd0;
      r_duty_b   <= 8'd0;
      r_presc    <= '0;
      r_dead_cnt <= '0;
      r_settled  <= 1'b0;
    end else if (estop) begin
      r_state    <= DEAD_TIME;
      r_duty_a   <= 8'd0;
      r_duty_b   <= 8'd0;
      r_presc    <= '0;
      r_dead_cnt <= '0;
      r_settled  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_presc   <= '0;
          r_settled <= 1'b0;
          if (req_duty_a != 8'd0 && req_duty_b == 8'd0)
            r_state <= RUN_A;
          else if (req_duty_b != 8'd0 && req_duty_a == 8'd0)
            r_state <= RUN_B;
        end
        RUN_A: begin
          r_duty_b <= 8'd0;
          if (r_duty_a == 8'd0 && w_tgt_a == 8'd0) begin
            r_state    <= DEAD_TIME;
            r_dead_cnt <= '0;
            r_settled  <= 1'b0;
          end else begin
            r_duty_a  <= w_next_a;
            r_presc   <= w_step ? '0 : r_presc + 1'b1;
            r_settled <= (w_next_a == w_tgt_a);
          end
        end
        RUN_B: begin
          r_duty_a <= 8'd0;
          if (r_duty_b == 8'd0 && w_tgt_b == 8'd0) begin
            r_state    <= DEAD_TIME;
            r_dead_cnt <= '0;
            r_settled  <= 1'b0;
          end else begin
            r_duty_b  <= w_next_b;
            r_presc   <= w_step ? '0 : r_presc + 1'b1;
            r_settled <= (w_next_b == w_tgt_b);
          end
        end
        default: begin
          r_duty_a  <= 8'd0;
          r_duty_b  <= 8'd0;
          r_settled <= 1'b0;
          if (r_dead_cnt == DEAD_LAST)
            r_state <= IDLE;
          else
            r_dead_cnt <= r_dead_cnt + 1'b1;
        end
      endcase
    end
  end

  assign pwm_duty_a = r_duty_a;
  assign pwm_duty_b = r_duty_b;
  assign busy       = (r_state != IDLE);
  assign settled    = r_settled;
  assign conflict   = (r_state == IDLE) && (req_duty_a != 8'd0) && (req_duty_b != 8'd0);

endmodule

// File: tb/tb_pump_drive_sequencer.sv
// tb/tb_pump_drive_sequencer.sv - randomized bench for pump_drive_sequencer against a behavioural model
module tb_pump_drive_sequencer;

  localparam int RAMP = 4;
  localparam int STEP = 10;
  localparam int DEAD = 8;
  localparam int M_IDLE = 0, M_A = 1, M_B = 2, M_DEAD = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] req_duty_a = 8'd0;
  logic [7:0] req_duty_b = 8'd0;
  logic       estop = 1'b0;
  logic [7:0] pwm_duty_a;
  logic [7:0] pwm_duty_b;
  logic       busy;
  logic       settled;
  logic       conflict;

  int n_checks = 0;
  int n_errors = 0;

  int m_mode, m_da, m_db, m_k, m_dcnt;
  bit m_settled;

  pump_drive_sequencer #(
    .RAMP_STEP_CYCLES(RAMP),
    .DUTY_STEP(STEP),
    .DEAD_TIME_CYCLES(DEAD)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_duty_a(req_duty_a),
    .req_duty_b(req_duty_b),
    .estop(estop),
    .pwm_duty_a(pwm_duty_a),
    .pwm_duty_b(pwm_duty_b),
    .busy(busy),
    .settled(settled),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  wire [18:0] w_obs = {pwm_duty_a, pwm_duty_b, busy, settled, conflict};

  function automatic int toward(int d, int t);
    if (d < t) return (d + STEP > t) ? t : d + STEP;
    if (d > t) return (d - STEP < t) ? t : d - STEP;
    return d;
  endfunction

  function automatic logic [18:0] expected();
    logic c;
    c = (m_mode == M_IDLE) && (req_duty_a != 8'd0) && (req_duty_b != 8'd0);
    return {8'(m_da), 8'(m_db), (m_mode != M_IDLE), m_settled, c};
  endfunction

  task automatic model_reset();
    m_mode = M_DEAD; m_dcnt = 0; m_da = 0; m_db = 0; m_k = 0; m_settled = 0;
  endtask

  // Spec rules applied once per clock edge, using the inputs present at that edge
  task automatic model_edge();
    int ta, tb2;
    ta  = (req_duty_b == 8'd0) ? int'(req_duty_a) : 0;
    tb2 = (req_duty_a == 8'd0) ? int'(req_duty_b) : 0;
    if (estop) begin
      m_mode = M_DEAD; m_dcnt = 0; m_da = 0; m_db = 0; m_settled = 0;
    end else begin
      case (m_mode)
        M_DEAD: begin
          m_settled = 0;
          if (m_dcnt == DEAD - 1) m_mode = M_IDLE;
          else m_dcnt++;
        end
        M_IDLE: begin
          m_k = 0;
          if (req_duty_a != 0 && req_duty_b == 0) m_mode = M_A;
          else if (req_duty_b != 0 && req_duty_a == 0) m_mode = M_B;
        end
        M_A: begin
          m_k++;
          if (m_da == 0 && ta == 0) begin
            m_mode = M_DEAD; m_dcnt = 0; m_settled = 0;
          end else begin
            if (m_k % RAMP == 0) m_da = toward(m_da, ta);
            m_settled = (m_da == ta);
          end
        end
        default: begin
          m_k++;
          if (m_db == 0 && tb2 == 0) begin
            m_mode = M_DEAD; m_dcnt = 0; m_settled = 0;
          end else begin
            if (m_k % RAMP == 0) m_db = toward(m_db, tb2);
            m_settled = (m_db == tb2);
          end
        end
      endcase
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (pwm_duty_a !== 8'd0 || pwm_duty_b !== 8'd0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_state: got a=%0d b=%0d busy=%b, expected 0 0 1", pwm_duty_a, pwm_duty_b, busy);
    end
    req_duty_a = 8'd230;
    reset_n = 1'b1;
    for (int i = 1; i <= 101; i++) begin
      tick();
      n_checks++;
      if (w_obs !== expected()) begin
        n_errors++;
        $display("FAIL reset_ramp cyc %0d: got %h expected %h", i, w_obs, expected());
      end
      if (i == 8 || i == 9) begin
        n_checks++;
        if (busy !== (i == 9)) begin
          n_errors++;
          $display("FAIL dead_to_idle cyc %0d: got busy=%b expected %b", i, busy, (i == 9));
        end
      end
    end
    n_checks++;
    if (pwm_duty_a !== 8'd230 || settled !== 1'b1) begin
      n_errors++;
      $display("FAIL ramp_230: got duty=%0d settled=%b, expected 230 1", pwm_duty_a, settled);
    end
    repeat (4) begin
      tick();
      n_checks++;
      if (settled !== 1'b1 || pwm_duty_a !== 8'd230) begin
        n_errors++;
        $display("FAIL hold_230: got duty=%0d settled=%b, expected 230 1", pwm_duty_a, settled);
      end
    end
  endtask

  task automatic test_handover();
    req_duty_a = 8'd0;
    req_duty_b = 8'd150;
    for (int i = 0; i < 400; i++) begin
      tick();
      n_checks++;
      if (w_obs !== expected() || (pwm_duty_a != 0 && pwm_duty_b != 0)) begin
        n_errors++;
        $display("FAIL handover cyc %0d: got %h expected %h", i, w_obs, expected());
      end
      if (m_mode == M_B && m_settled) break;
    end
    n_checks++;
    if (pwm_duty_b !== 8'd150 || pwm_duty_a !== 8'd0) begin
      n_errors++;
      $display("FAIL handover_final: got a=%0d b=%0d, expected 0 150", pwm_duty_a, pwm_duty_b);
    end
  endtask

  task automatic test_estop();
    estop = 1'b1;
    tick();
    n_checks++;
    if (pwm_duty_b !== 8'd0 || busy !== 1'b1 || w_obs !== expected()) begin
      n_errors++;
      $display("FAIL estop_pulse: got %h expected %h", w_obs, expected());
    end
    estop = 1'b0;
    repeat (3) begin
      tick();
      n_checks++;
      if (w_obs !== expected()) begin
        n_errors++;
        $display("FAIL estop_after: got %h expected %h", w_obs, expected());
      end
    end
    estop = 1'b1;
    repeat (20) begin
      tick();
      n_checks++;
      if (busy !== 1'b1 || w_obs !== expected()) begin
        n_errors++;
        $display("FAIL estop_hold: got %h expected %h", w_obs, expected());
      end
    end
    estop = 1'b0;
    req_duty_b = 8'd0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_checks++;
      if (busy !== (i < 8) || w_obs !== expected()) begin
        n_errors++;
        $display("FAIL estop_release cyc %0d: got %h expected %h", i, w_obs, expected());
      end
    end
  endtask

  task automatic test_saturate();
    bit did_eq = 0;
    req_duty_a = 8'd77;
    for (int i = 0; i < 80; i++) begin
      tick();
      n_checks++;
      if (w_obs !== expected() || pwm_duty_a > 8'd77) begin
        n_errors++;
        $display("FAIL saturate cyc %0d: got %h expected %h", i, w_obs, expected());
      end
      if (m_da == 40 && !did_eq) begin
        did_eq = 1;
        req_duty_a = 8'd40;
        tick();
        n_checks++;
        if (settled !== 1'b1 || pwm_duty_a !== 8'd40) begin
          n_errors++;
          $display("FAIL equal_request: got duty=%0d settled=%b, expected 40 1", pwm_duty_a, settled);
        end
        req_duty_a = 8'd77;
      end
      if (m_settled && m_da == 77) break;
    end
    n_checks++;
    if (pwm_duty_a !== 8'd77 || settled !== 1'b1) begin
      n_errors++;
      $display("FAIL saturate_77: got duty=%0d settled=%b, expected 77 1", pwm_duty_a, settled);
    end
    req_duty_a = 8'd0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n_checks++;
      if (w_obs !== expected()) begin
        n_errors++;
        $display("FAIL ramp_down cyc %0d: got %h expected %h", i, w_obs, expected());
      end
      if (m_mode == M_IDLE) break;
    end
  endtask

  task automatic test_conflict();
    req_duty_a = 8'd100;
    req_duty_b = 8'd100;
    repeat (3) begin
      tick();
      n_checks++;
      if (conflict !== 1'b1 || busy !== 1'b0 || pwm_duty_a !== 8'd0 || pwm_duty_b !== 8'd0) begin
        n_errors++;
        $display("FAIL conflict: got %h expected conflict=1 busy=0 duties 0", w_obs);
      end
    end
    req_duty_b = 8'd0;
    #1;
    n_checks++;
    if (conflict !== 1'b0) begin
      n_errors++;
      $display("FAIL conflict_clear: got %b expected 0", conflict);
    end
    tick();
    n_checks++;
    if (busy !== 1'b1 || w_obs !== expected()) begin
      n_errors++;
      $display("FAIL conflict_grant: got %h expected %h", w_obs, expected());
    end
  endtask

  task automatic test_reset_midramp();
    for (int i = 0; i < 40; i++) begin
      if (m_da == 60) break;
      tick();
      n_checks++;
      if (w_obs !== expected()) begin
        n_errors++;
        $display("FAIL midramp cyc %0d: got %h expected %h", i, w_obs, expected());
      end
    end
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (pwm_duty_a !== 8'd0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL async_reset: got duty=%0d busy=%b, expected 0 1", pwm_duty_a, busy);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_checks++;
      if (w_obs !== expected()) begin
        n_errors++;
        $display("FAIL post_reset cyc %0d: got %h expected %h", i, w_obs, expected());
      end
      if (i == 12 || i == 13) begin
        n_checks++;
        if (pwm_duty_a !== ((i == 13) ? 8'd10 : 8'd0)) begin
          n_errors++;
          $display("FAIL post_reset_step cyc %0d: got %0d", i, pwm_duty_a);
        end
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        r = $urandom_range(0, 5);
        case (r)
          0: begin req_duty_a = 8'($urandom_range(1, 255)); req_duty_b = 8'd0; end
          1: begin req_duty_a = 8'd0; req_duty_b = 8'($urandom_range(1, 255)); end
          2: begin req_duty_a = 8'd0; req_duty_b = 8'd0; end
          3: begin req_duty_a = 8'($urandom_range(1, 255)); req_duty_b = 8'($urandom_range(1, 255)); end
          4: req_duty_a = 8'(m_da);
          default: req_duty_b = 8'($urandom_range(0, 255));
        endcase
      end
      estop = ($urandom_range(0, 299) == 0);
      tick();
      n_checks++;
      if (w_obs !== expected() || (pwm_duty_a != 0 && pwm_duty_b != 0)) begin
        n_errors++;
        $display("FAIL random cyc %0d: got %h expected %h", i, w_obs, expected());
      end
    end
    estop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_handover();
    test_estop();
    test_saturate();
    test_conflict();
    test_reset_midramp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pump_drive_sequencer.md
Name: pump_drive_sequencer

Overview:
- Sits between the filter control FSM and the pump PWM generators.
- Takes raw duty requests for pump A (fill) and pump B (drain) and produces the slew-limited duties actually applied.
- Only one pump is ever driven at a time, with an enforced all-off dead time between ownership changes.
- Adds a synchronous emergency stop and a settled/busy status for supervision.

Parameters:
RAMP_STEP_CYCLES, 500_000, clock cycles between duty steps (10 ms @ 50 MHz); legal range >= 1
DUTY_STEP, 5, duty counts added or removed per step; legal range 1..255
DEAD_TIME_CYCLES, 25_000_000, all-off cycles between ownership changes (0.5 s @ 50 MHz); legal range >= 1

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
req_duty_a  input  8  requested duty for pump A; 0 = off
req_duty_b  input  8  requested duty for pump B; 0 = off
estop  input  1  synchronous active-high emergency stop
pwm_duty_a  output  8  applied duty, pump A (registered)
pwm_duty_b  output  8  applied duty, pump B (registered)
busy  output  1  state != IDLE
settled  output  1  in RUN_A/RUN_B and applied duty == current target
conflict  output  1  in IDLE with both requests nonzero

Behaviour:
Reset:
- reset_n low immediately forces pwm_duty_a = pwm_duty_b = 0, with no clock edge required.
- State is forced to DEAD_TIME with its counter at 0, so pumps stay off DEAD_TIME_CYCLES after release.
- All outputs are registered or decoded from state; no output combinationally depends on the req_* inputs, except conflict (IDLE only).

States:
- IDLE
  - Both duties are 0.
  - req_a != 0 and req_b == 0: go to RUN_A on the next cycle.
  - req_b != 0 and req_a == 0: go to RUN_B.
  - Both nonzero: stay in IDLE with conflict = 1; no pump is granted.
  - Both zero: stay in IDLE.
- RUN_A
  - Owner is A; pwm_duty_b is held at 0.
  - target = req_a if req_b == 0, else 0 (a request from the other pump forces A to ramp down).
  - The step prescaler clears on state entry. A step fires when the prescaler reaches RAMP_STEP_CYCLES-1, so the first step lands RAMP_STEP_CYCLES cycles after entry.
  - On each step, the duty moves toward target by DUTY_STEP and saturates exactly at target; it never overshoots.
  - Step arithmetic uses a 9-bit difference, with no wrap at 0 or 255.
  - target is re-evaluated on every step, so mid-ramp retargeting is legal, including reversing direction.
  - When pwm_duty_a == 0 and target == 0, go to DEAD_TIME.
- RUN_B: mirror of RUN_A with A and B swapped.
- DEAD_TIME
  - Both duties are 0.
  - The counter runs 0..DEAD_TIME_CYCLES-1, then the state goes to IDLE.
  - While estop = 1, the counter is held at 0.
- estop
  - Sampled on every clock edge. If high in any state, both duties are 0 on the following edge, the state goes to DEAD_TIME and the counter clears.
  - There is no ramp-down on estop.
  - estop has priority over every other transition.

Invariants and boundaries:
- pwm_duty_a and pwm_duty_b are never nonzero in the same cycle.
- A request equal to the current duty gives settled = 1 with no step applied.
- A request change that lands exactly on a step cycle uses the new target on that step.
- req_* of 255 with DUTY_STEP = 5 reaches 255 exactly; no overflow.
- Simultaneous release of A and request of B: A ramps down, then dead time, then B ramps up.

Test Plan:
All scenarios use RAMP_STEP_CYCLES=4, DUTY_STEP=10, DEAD_TIME_CYCLES=8.
1. Release reset with req_a=230, req_b=0 -> duties 0 for 8 cycles, IDLE for 1 cycle, RUN_A; pwm_duty_a=10 four cycles after entry, +10 every 4 cycles, reaches 230 after 23 steps (92 cycles); settled=1 from then on.
2. req_a=77 from IDLE -> pwm_duty_a steps 10,20,...,70,77; the 8th step saturates at 77, never 80.
3. A settled at 230, then req_a=0 and req_b=150 in the same cycle -> A ramps 220..0 over 23 steps with pwm_duty_b=0 throughout; 8 dead-time cycles with both 0; IDLE; B ramps to 150 in 15 steps; the checker asserts A and B are never both nonzero.
4. From IDLE, req_a=100 and req_b=100 -> conflict=1, duties stay 0, busy=0; drop req_b to 0 -> conflict=0 and RUN_A is entered on the next cycle.
5. pwm_duty_b=150 in RUN_B, estop pulsed for 1 cycle -> pwm_duty_b=0 on the next edge, state DEAD_TIME; estop held for 20 cycles -> state stays DEAD_TIME, and IDLE follows 8 cycles after estop falls.
6. Assert reset_n mid-ramp (pwm_duty_a=60) between clock edges -> pwm_duty_a=0 immediately; after release, the 8-cycle dead time runs before any ramp.
